ripple_count_ctrl: RTL and testbench

- Synchronous sequencer that drives an external WIDTH-bit asynchronous ripple counter (up or down variant, D-FF based, posedge-clocked, async active-low clear) to a requested value.
- Generates the counter's clear, clock pulses and direction select; waits a settle window after each pulse for ripple propagation; samples the counter and stops on match.
- Sits between a host start/done handshake and the ripple counter datapath.

---
 rtl/ripple_count_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_ripple_count_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_ctrl.sv
// ripple_count_ctrl
// -----------------
// Synchronous sequencer for an external WIDTH-bit asynchronous ripple counter
// (up or down variant, posedge-clocked, async active-low clear). On a host start
// it clears the counter and then issues single clock pulses. After the clear and
// after every pulse it waits SETTLE cycles for the ripple to propagate, samples
// cnt_val, and stops when the sample equals the requested target. If 2^WIDTH
// pulses have been issued without a match, it reports an error.
//
// Parameters
//   WIDTH   counter width in bits
//   SETTLE  clk cycles waited after each pulse/clear before sampling (1..15)
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   start      operation request, accepted only while idle
//   dir        0 = up counter, 1 = down counter (latched on start)
//   target     value to reach (latched on start)
//   abort      cancels any active operation, with no done pulse
//   busy       high whenever an operation is in progress
//   done       one-cycle completion pulse
//   err        valid with done; 1 = target not reached
//   count_q    last sampled cnt_val
//   pulses     counter clock pulses issued in the current/last operation
//   cnt_clk    registered clock to the ripple counter
//   cnt_rst_n  registered active-low clear to the ripple counter
//   cnt_dir    latched dir, selects the up/down counter variant
//   cnt_val    ripple counter output
//   step_err   (RIPPLE_STEP_CHECK_EN only) the counter did not advance by exactly one step
//
// Build option
//   RIPPLE_STEP_CHECK_EN  When defined, each sample is also checked against the
//                         value expected one step after the previous sample.
//                         The first sample after a clear must be 0. A mismatch
//                         ends the operation with err=1 and step_err=1.

module ripple_count_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] target,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] count_q,
  output logic [WIDTH:0]   pulses,
`ifdef RIPPLE_STEP_CHECK_EN
  output logic             step_err,
`endif
  output logic             cnt_clk,
  output logic             cnt_rst_n,
  output logic             cnt_dir,
  input  logic [WIDTH-1:0] cnt_val
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSettle,
    StCheck,
    StPulseHi,
    StPulseLo,
    StDone
  } state_e;

  // One full wrap of the counter: reaching this without a match is an error.
  localparam logic [WIDTH:0]   PulseMax   = {1'b1, {WIDTH{1'b0}}};
  localparam logic [3:0]       SettleLast = 4'(SETTLE - 1);
  localparam logic [3:0]       ClearLast  = 4'd1;
  localparam logic [WIDTH-1:0] One        = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state;
  logic [WIDTH-1:0] tgt;
  logic [3:0]       wait_cnt;

`ifdef RIPPLE_STEP_CHECK_EN
  logic             first_chk;
  logic [WIDTH-1:0] step_exp;
  logic             step_bad;

  // The sample right after the clear must be 0. Each later sample must be one
  // step from the previous sample in the latched direction.
  always_comb begin
    step_exp = '0;
    if (!first_chk) begin
      step_exp = cnt_dir ? (count_q - One) : (count_q + One);
    end
    step_bad = (cnt_val != step_exp);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      tgt       <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      count_q   <= '0;
      pulses    <= '0;
      cnt_clk   <= 1'b0;
      cnt_rst_n <= 1'b0;
      cnt_dir   <= 1'b0;
`ifdef RIPPLE_STEP_CHECK_EN
      step_err  <= 1'b0;
      first_chk <= 1'b0;
`endif
    end else if (abort && (state != StIdle)) begin
      // Abort wins over everything, including a match in StCheck.
      // count_q and pulses keep their values for inspection.
      state     <= StIdle;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt_clk   <= 1'b0;
      cnt_rst_n <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          done      <= 1'b0;
          cnt_clk   <= 1'b0;
          cnt_rst_n <= 1'b1;
          if (start) begin
            tgt       <= target;
            cnt_dir   <= dir;
            pulses    <= '0;
            err       <= 1'b0;
            wait_cnt  <= '0;
            busy      <= 1'b1;
            cnt_rst_n <= 1'b0;
            state     <= StClear;
`ifdef RIPPLE_STEP_CHECK_EN
            step_err  <= 1'b0;
            first_chk <= 1'b1;
`endif
          end
        end

        // Clear is held low for two cycles.
        StClear: begin
          if (wait_cnt == ClearLast) begin
            wait_cnt  <= '0;
            cnt_rst_n <= 1'b1;
            state     <= StSettle;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        // Give the ripple chain time to settle before sampling.
        StSettle: begin
          cnt_clk   <= 1'b0;
          cnt_rst_n <= 1'b1;
          if (wait_cnt == SettleLast) begin
            wait_cnt <= '0;
            state    <= StCheck;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        StCheck: begin
          count_q <= cnt_val;
`ifdef RIPPLE_STEP_CHECK_EN
          first_chk <= 1'b0;
          if (step_bad) begin
            err      <= 1'b1;
            step_err <= 1'b1;
            done     <= 1'b1;
            state    <= StDone;
          end else
`endif
          if (cnt_val == tgt) begin
            err   <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end else if (pulses == PulseMax) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= StDone;
          end else begin
            // The pulse count advances on the same edge that raises cnt_clk.
            cnt_clk <= 1'b1;
            pulses  <= pulses + 1'b1;
            state   <= StPulseHi;
          end
        end

        StPulseHi: begin
          cnt_clk <= 1'b0;
          state   <= StPulseLo;
        end

        StPulseLo: begin
          wait_cnt <= '0;
          state    <= StSettle;
        end

        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end

        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          cnt_clk   <= 1'b0;
          cnt_rst_n <= 1'b1;
          state     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_count_ctrl.sv
module tb_ripple_count_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned S = 3;
`ifdef RIPPLE_STEP_CHECK_EN
  localparam bit STEP = 1'b1;
`else
  localparam bit STEP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic [W-1:0] target = '0;
  logic         abort = 1'b0;
  logic         busy, done, err;
  logic [W-1:0] count_q;
  logic [W:0]   pulses;
  logic         cnt_clk, cnt_rst_n, cnt_dir;
  logic [W-1:0] cnt_val;
`ifdef RIPPLE_STEP_CHECK_EN
  logic         step_err;
`endif

  ripple_count_ctrl #(.WIDTH(W), .SETTLE(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .target    (target),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count_q   (count_q),
    .pulses    (pulses),
`ifdef RIPPLE_STEP_CHECK_EN
    .step_err  (step_err),
`endif
    .cnt_clk   (cnt_clk),
    .cnt_rst_n (cnt_rst_n),
    .cnt_dir   (cnt_dir),
    .cnt_val   (cnt_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ripple counter; "stuck" forces its output to 0.
  logic [W-1:0] cnt;
  bit           stuck = 1'b0;
  always @(posedge cnt_clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) cnt <= '0;
    else            cnt <= cnt_dir ? cnt - 1'b1 : cnt + 1'b1;
  end
  assign cnt_val = stuck ? '0 : cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic         d;
    logic         err;
    logic         serr;
    logic [W-1:0] cq;
    logic [W:0]   pulses;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];

  // Reference: number of pulses needed from a cleared counter, and the outcome.
  function automatic exp_t model(input bit d, input logic [W-1:0] t, input bit s);
    exp_t e;
    int   p;
    int   m = 1 << W;
    e.d    = d;
    e.serr = 1'b0;
    if (s && t != 0) begin
      e.cq  = '0;
      e.err = 1'b1;
      if (STEP) begin
        p      = 1;
        e.serr = 1'b1;
      end else begin
        p = m;
      end
    end else begin
      p     = d ? (m - int'(t)) % m : int'(t);
      e.cq  = t;
      e.err = 1'b0;
    end
    e.pulses = p[W:0];
    e.lat    = 2 + (S + 1) + p * (S + 3);
    e.t0     = 0;
    return e;
  endfunction

  // Monitor: scoreboard pop on done, clear-length and glitch-free output checks.
  initial begin
    logic prev_clk, prev_rn;
    bit   prev_ok = 1'b0;
    int   run = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (prev_ok && (cnt_clk !== prev_clk || cnt_rst_n !== prev_rn))
          chk("clk_and_clear_same_cycle",
              32'((cnt_clk !== prev_clk) && (cnt_rst_n !== prev_rn)), 0);
        if (busy && !cnt_rst_n) run++;
        else if (run > 0) begin
          chk("clear_low_cycles", run, 2);
          run = 0;
        end
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("done_latency", cyc - e.t0, e.lat);
            chk("err", err, e.err);
            chk("count_q", count_q, e.cq);
            chk("pulses", pulses, e.pulses);
            chk("busy_at_done", busy, 1);
            chk("cnt_dir", cnt_dir, e.d);
`ifdef RIPPLE_STEP_CHECK_EN
            chk("step_err", step_err, e.serr);
`endif
          end
        end
        prev_ok = 1'b1;
      end else begin
        prev_ok = 1'b0;
        run     = 0;
      end
      prev_clk = cnt_clk;
      prev_rn  = cnt_rst_n;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Issue one operation (at a negedge, start accepted at the next posedge).
  task automatic issue(input bit d, input logic [W-1:0] t, input bit s, input int hold);
    exp_t e;
    wait_idle();
    e     = model(d, t, s);
    e.t0  = cyc + 1;
    stuck = s;
    dir   = d;
    target = t;
    start = 1'b1;
    sb.push_back(e);
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input bit d, input logic [W-1:0] t, input bit s);
    issue(d, t, s, 1);
    wait_empty();
  endtask

  initial begin
    int n;
    int hi_n;
    logic prev;

    // Reset values.
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count_q", count_q, 0);
    chk("rst_pulses", pulses, 0);
    chk("rst_cnt_clk", cnt_clk, 0);
    chk("rst_cnt_rst_n", cnt_rst_n, 0);
    chk("rst_cnt_dir", cnt_dir, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("clear_released_after_reset", cnt_rst_n, 1);

    // Directed operations.
    run_op(1'b0, 4'd5, 1'b0);
    run_op(1'b1, 4'd13, 1'b0);
    run_op(1'b0, 4'd0, 1'b0);
    run_op(1'b1, 4'd0, 1'b0);
    run_op(1'b0, 4'd9, 1'b1);

    // Abort in the third pulse-high cycle of a target=10 run.
    wait_idle();
    stuck  = 1'b0;
    dir    = 1'b0;
    target = 4'd10;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hi_n = 0;
    n    = 0;
    prev = cnt_clk;
    while (hi_n < 3 && n < 200) begin
      @(negedge clk);
      if (cnt_clk && !prev) hi_n++;
      prev = cnt_clk;
      n++;
    end
    chk("abort_reached_third_pulse", hi_n, 3);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_cnt_clk", cnt_clk, 0);
    chk("abort_cnt_rst_n", cnt_rst_n, 1);
    chk("abort_done", done, 0);
    chk("abort_pulses", pulses, 3);
    chk("abort_count_q", count_q, 2);
    @(negedge clk);
    abort = 1'b0;
    run_op(1'b0, 4'd2, 1'b0);

    // Start held high while busy must not launch a second operation.
    issue(1'b0, 4'd3, 1'b0, 10);
    wait_empty();
    repeat (30) @(negedge clk);
    chk("held_start_no_second_op", busy, 0);

    // Randomized operations.
    for (int i = 0; i < 20; i++) begin
      run_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
    end

    // Reset during the settle window, with start held high.
    wait_idle();
    stuck  = 1'b0;
    dir    = 1'b1;
    target = 4'd7;
    start  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(busy && cnt_rst_n) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_settle", 32'(busy && cnt_rst_n), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_count_q", count_q, 0);
    chk("midrst_pulses", pulses, 0);
    chk("midrst_cnt_clk", cnt_clk, 0);
    chk("midrst_cnt_rst_n", cnt_rst_n, 0);
    chk("midrst_cnt_dir", cnt_dir, 0);
`ifdef RIPPLE_STEP_CHECK_EN
    chk("midrst_step_err", step_err, 0);
`endif
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cnt_rst_n", cnt_rst_n, 1);
    run_op(1'b1, 4'd4, 1'b0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
